// File: rtl/cmd_pkg.sv
// Shared constants, parser state encoding and the CRC-8/0x07 step for the command-frame controller.
package cmd_pkg;

    localparam logic [7:0] SYNC          = 8'hAA;
    localparam logic [7:0] CMD_SWAP      = 8'h01;
    localparam logic [7:0] CMD_CLEAR     = 8'h02;
    localparam logic [7:0] CMD_LOAD_EDGE = 8'h05;
    localparam logic [7:0] CMD_STATUS    = 8'h07;
    localparam logic [7:0] RESP_LEN      = 8'h04;
    localparam logic [7:0] RESP_STATUS   = 8'h87;

    typedef enum logic [2:0] {
        ST_HUNT, ST_LEN, ST_BODY, ST_CHECK, ST_EXEC, ST_WAIT_CLR, ST_WAIT_SWP, ST_RESP
    } state_t;

    typedef enum logic [1:0] {TX_IDLE, TX_RISE, TX_FALL} tx_phase_t;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_step.sv
// Byte-serial CRC-8 (poly 0x07, init 0x00, MSB first); one byte folded in per enabled cycle.
module crc8_step
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_next(crc, data);
        end
    end

endmodule

// File: rtl/cmd_frame_ctrl.sv
// UART command-frame parser: validates AA/LEN/CMD/payload/CRC frames and drives swap, clear,
// edge-RAM load and status-response side effects, one frame at a time.
module cmd_frame_ctrl
    import cmd_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned TIMEOUT_CYC = 3200
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        clear_start,
    output logic [7:0]  clear_color,
    input  logic        clear_busy,
    output logic        swap_req,
    input  logic        swap_ack,
    output logic        edge_we,
    output logic [7:0]  edge_addr,
    output logic [15:0] edge_wdata,
    output logic [7:0]  err_cnt
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    state_t    state, state_nxt;
    tx_phase_t tx_phase;

    logic [7:0]    body_mem [MAX_LEN];
    logic [7:0]    len_q, cnt, edge_ptr, color_q, stat_q, err_q, rcrc_q, crc_val;
    logic [TW-1:0] tcnt;
    logic [3:0]    widx, nwords;
    logic [2:0]    resp_idx;
    logic          crc_ok, last_err;
    logic          reject, accept, crc_clr, crc_en, cmd_ok;

    crc8_step u_crc (
        .clk  (CLK),
        .rst  (rst),
        .clr  (crc_clr),
        .en   (crc_en),
        .data (rx_data),
        .crc  (crc_val)
    );

    logic [7:0]    cmd, edge_n, edge_base, stat_now, resp_crc;
    logic          edge_cont, edge_ovf, len_bad, body_last, timeout;
    logic [9:0]    edge_end;
    logic [AW-1:0] word_idx;

    assign cmd       = body_mem[0];
    assign edge_n    = body_mem[1];
    assign edge_cont = body_mem[2][2];
    assign edge_base = edge_cont ? edge_ptr : 8'd0;
    // End pointer after 3N writes; reaching 256 would wrap the pointer, so it is rejected up front.
    assign edge_end  = 10'(edge_base) + 10'(edge_n) + {1'b0, edge_n, 1'b0};
    assign edge_ovf  = edge_end > 10'd255;
    assign len_bad   = (rx_data < 8'd2) || (rx_data > 8'(MAX_LEN));
    assign body_last = (cnt == len_q - 8'd1);
    assign timeout   = !rx_valid && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign stat_now  = {edge_ptr[4:0], swap_req, clear_busy, last_err};
    assign resp_crc  = crc8_next(crc8_next(crc8_next(crc8_next(8'h00, RESP_LEN),
                                 RESP_STATUS), stat_now), err_cnt);
    assign word_idx  = AW'({widx, 1'b0}) + AW'(3);

    assign edge_addr   = edge_ptr;
    assign edge_wdata  = {body_mem[word_idx], body_mem[word_idx + AW'(1)]};
    assign clear_color = clear_start ? body_mem[1] : color_q;

    always_comb begin
        cmd_ok = 1'b0;
        case (cmd)
            CMD_SWAP, CMD_STATUS: cmd_ok = (len_q == 8'd2);
            CMD_CLEAR:            cmd_ok = (len_q == 8'd3);
            CMD_LOAD_EDGE:        cmd_ok = (edge_n != 8'd0) && (edge_n <= 8'd4) &&
                                           (len_q == 8'd4 + 8'd6 * edge_n) && !edge_ovf;
            default:              cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (resp_idx)
            3'd0:    tx_data = SYNC;
            3'd1:    tx_data = RESP_LEN;
            3'd2:    tx_data = RESP_STATUS;
            3'd3:    tx_data = stat_q;
            3'd4:    tx_data = err_q;
            default: tx_data = rcrc_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        reject      = 1'b0;
        accept      = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        tx_start    = 1'b0;
        clear_start = 1'b0;
        swap_req    = 1'b0;
        edge_we     = 1'b0;
        case (state)
            ST_HUNT: begin
                crc_clr = 1'b1;
                if (rx_valid && rx_data == SYNC) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (len_bad) begin
                        reject    = 1'b1;
                        state_nxt = ST_HUNT;
                    end else begin
                        crc_en    = 1'b1;
                        state_nxt = ST_BODY;
                    end
                end else if (timeout) begin
                    reject    = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            ST_BODY: begin
                if (rx_valid) begin
                    if (body_last) state_nxt = ST_CHECK;
                    else           crc_en    = 1'b1;
                end else if (timeout) begin
                    reject    = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            ST_CHECK: begin
                if (crc_ok && cmd_ok) begin
                    accept = 1'b1;
                    case (cmd)
                        CMD_SWAP:      state_nxt = ST_WAIT_SWP;
                        CMD_CLEAR:     state_nxt = ST_WAIT_CLR;
                        CMD_LOAD_EDGE: state_nxt = ST_EXEC;
                        default:       state_nxt = ST_RESP;
                    endcase
                end else begin
                    reject    = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            ST_EXEC: begin
                edge_we = 1'b1;
                if (widx == nwords - 4'd1) state_nxt = ST_HUNT;
            end
            ST_WAIT_CLR: begin
                if (!clear_busy) begin
                    clear_start = 1'b1;
                    state_nxt   = ST_HUNT;
                end
            end
            ST_WAIT_SWP: begin
                swap_req = 1'b1;
                if (swap_ack) state_nxt = ST_HUNT;
            end
            ST_RESP: begin
                if (tx_phase == TX_IDLE && !tx_busy) tx_start = 1'b1;
                if (tx_phase == TX_FALL && !tx_busy && resp_idx == 3'd5) state_nxt = ST_HUNT;
            end
            default: state_nxt = ST_HUNT;
        endcase
        if (rst) begin
            tx_start    = 1'b0;
            clear_start = 1'b0;
            swap_req    = 1'b0;
            edge_we     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == ST_BODY && rx_valid && !body_last) begin
            body_mem[cnt[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            len_q    <= '0;
            cnt      <= '0;
            crc_ok   <= 1'b0;
            tcnt     <= '0;
            err_cnt  <= '0;
            last_err <= 1'b0;
            edge_ptr <= '0;
            color_q  <= '0;
            widx     <= '0;
            nwords   <= '0;
            resp_idx <= '0;
            tx_phase <= TX_IDLE;
            stat_q   <= '0;
            err_q    <= '0;
            rcrc_q   <= '0;
        end else begin
            if ((state == ST_LEN || state == ST_BODY) && !rx_valid) tcnt <= tcnt + TW'(1);
            else                                                     tcnt <= '0;
            if (state == ST_LEN && rx_valid) begin
                len_q <= rx_data;
                cnt   <= '0;
            end
            if (state == ST_BODY && rx_valid) begin
                if (body_last) crc_ok <= (rx_data == crc_val);
                else           cnt    <= cnt + 8'd1;
            end
            if (reject) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                last_err <= 1'b1;
            end
            // Status fields are snapshotted before this frame clears last_err.
            if (accept) begin
                last_err <= 1'b0;
                stat_q   <= stat_now;
                err_q    <= err_cnt;
                rcrc_q   <= resp_crc;
                resp_idx <= '0;
                tx_phase <= TX_IDLE;
                widx     <= '0;
                nwords   <= edge_n[3:0] + {edge_n[2:0], 1'b0};
                if (cmd == CMD_LOAD_EDGE && !edge_cont) edge_ptr <= '0;
            end
            if (edge_we) begin
                edge_ptr <= edge_ptr + 8'd1;
                widx     <= widx + 4'd1;
            end
            if (clear_start) color_q <= body_mem[1];
            if (state == ST_RESP) begin
                case (tx_phase)
                    TX_IDLE: if (!tx_busy) tx_phase <= TX_RISE;
                    TX_RISE: if (tx_busy)  tx_phase <= TX_FALL;
                    TX_FALL: if (!tx_busy) begin
                        tx_phase <= TX_IDLE;
                        resp_idx <= resp_idx + 3'd1;
                    end
                    default: tx_phase <= TX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Directed self-checking bench for cmd_frame_ctrl with a simple UART-TX busy model.
module tb_cmd_frame_ctrl;

    logic        CLK = 1'b0;
    logic        rst, rx_valid, tx_start, tx_busy, clear_start, clear_busy;
    logic        swap_req, swap_ack, edge_we;
    logic [7:0]  rx_data, tx_data, clear_color, edge_addr, err_cnt;
    logic [15:0] edge_wdata;

    always #5 CLK = ~CLK;

    cmd_frame_ctrl #(.MAX_LEN(32), .TIMEOUT_CYC(64)) dut (
        .CLK         (CLK),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .edge_we     (edge_we),
        .edge_addr   (edge_addr),
        .edge_wdata  (edge_wdata),
        .err_cnt     (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    int          clr_n = 0;
    logic [7:0]  clr_col = 8'h00;
    int          wr_n = 0;
    logic [7:0]  wr_addr [64];
    logic [15:0] wr_data [64];
    int          tx_n = 0;
    logic [7:0]  tx_log [32];
    int          tx_viol = 0;
    logic [7:0]  fq [$];

    always @(negedge CLK) begin
        if (clear_start === 1'b1) begin
            clr_n++;
            clr_col = clear_color;
        end
        if (edge_we === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = edge_addr;
                wr_data[wr_n] = edge_wdata;
            end
            wr_n++;
        end
        if (tx_start === 1'b1) begin
            if (tx_busy) tx_viol++;
            if (tx_n < 32) tx_log[tx_n] = tx_data;
            tx_n++;
        end
    end

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (tx_start === 1'b1) begin
                @(posedge CLK);
                #1 tx_busy = 1'b1;
                repeat (4) @(posedge CLK);
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_fq();
        for (int i = 0; i < fq.size(); i++) send_byte(fq[i]);
    endtask

    task automatic begin_frame(input logic [7:0] len, input logic [7:0] cmd);
        fq.delete();
        fq.push_back(8'hAA);
        fq.push_back(len);
        fq.push_back(cmd);
    endtask

    task automatic add_crc();
        logic [7:0] c;
        c = 8'h00;
        for (int i = 1; i < fq.size(); i++) c = ref_crc(c, fq[i]);
        fq.push_back(c);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [7:0] stat, input logic [7:0] err);
        int         t0;
        logic [7:0] exp [6];
        t0 = tx_n;
        begin_frame(8'h02, 8'h07);
        fq.push_back(8'h3F);
        send_fq();
        for (int i = 0; i < 400 && tx_n < t0 + 6; i++) @(posedge CLK);
        #1;
        check({tag, "_count"}, tx_n - t0, 6);
        exp[0] = 8'hAA; exp[1] = 8'h04; exp[2] = 8'h87; exp[3] = stat; exp[4] = err;
        exp[5] = ref_crc(ref_crc(ref_crc(ref_crc(8'h00, 8'h04), 8'h87), stat), err);
        if (tx_n >= t0 + 6) begin
            for (int i = 0; i < 6; i++) check({tag, "_byte"}, {i[7:0], tx_log[t0 + i]}, {i[7:0], exp[i]});
        end
        wait_cyc(12);
        check({tag, "_no_tx_while_busy"}, tx_viol, 0);
    endtask

    int base, w0;

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clear_busy = 1'b0; swap_ack = 1'b0;
        wait_cyc(3);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_swap_req", swap_req, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_clear_start", clear_start, 0);
        check("rst_edge_we", edge_we, 0);
        check("rst_clear_color", clear_color, 0);
        rst = 1'b0;

        // CLEAR with idle engine, including 2-cycle latency
        base = clr_n;
        begin_frame(8'h03, 8'h02); fq.push_back(8'h00); fq.push_back(8'h97);
        send_fq();
        @(negedge CLK);
        check("clr_not_early", clear_start, 0);
        @(negedge CLK);
        check("clr_latency", clear_start, 1);
        check("clr_color0", clear_color, 8'h00);
        wait_cyc(3);
        check("clr_once", clr_n, base + 1);
        check("clr_err_unchanged", err_cnt, 0);

        // CLEAR while engine busy must wait
        clear_busy = 1'b1;
        begin_frame(8'h03, 8'h02); fq.push_back(8'h55); add_crc();
        send_fq();
        wait_cyc(10);
        check("clr_busy_wait", clr_n, base + 1);
        check("clr_color_held", clear_color, 8'h00);
        clear_busy = 1'b0;
        @(negedge CLK);
        check("clr_after_busy", clear_start, 1);
        check("clr_color55", clear_color, 8'h55);
        wait_cyc(3);
        check("clr_color55_stable", clear_color, 8'h55);
        check("clr_count2", clr_n, base + 2);

        // SWAP held for 1000 cycles; rx traffic meanwhile is ignored
        begin_frame(8'h02, 8'h01); fq.push_back(8'h2D);
        send_fq();
        @(negedge CLK); @(negedge CLK);
        check("swap_latency", swap_req, 1);
        base = clr_n;
        begin_frame(8'h03, 8'h02); fq.push_back(8'h00); fq.push_back(8'h97);
        send_fq();
        wait_cyc(1000);
        check("swap_held", swap_req, 1);
        check("swap_ignored_rx", clr_n, base);
        check("swap_err", err_cnt, 0);
        @(posedge CLK); #1 swap_ack = 1'b1;
        @(negedge CLK);
        check("swap_ack_cycle", swap_req, 1);
        @(posedge CLK); #1 swap_ack = 1'b0;
        check("swap_dropped", swap_req, 0);

        // LOAD_EDGE head frame, N=3, CONT=0
        w0 = wr_n;
        begin_frame(8'h16, 8'h05); fq.push_back(8'h03); fq.push_back(8'h00);
        for (int k = 1; k <= 9; k++) begin fq.push_back(8'h00); fq.push_back(8'(k * 17)); end
        add_crc();
        send_fq();
        @(negedge CLK);
        check("edge_not_early", edge_we, 0);
        @(negedge CLK);
        check("edge_latency", edge_we, 1);
        wait_cyc(12);
        check("edge_head_count", wr_n - w0, 9);
        for (int k = 0; k < 9; k++) begin
            check("edge_head_addr", wr_addr[w0 + k], k);
            check("edge_head_data", wr_data[w0 + k], 16'h0011 * (k + 1));
        end

        // LOAD_EDGE continuation, CONT=1
        begin_frame(8'h16, 8'h05); fq.push_back(8'h03); fq.push_back(8'h04);
        for (int k = 0; k < 9; k++) begin fq.push_back(8'h00); fq.push_back(8'(8'h77 + k * 17)); end
        add_crc();
        send_fq();
        wait_cyc(14);
        check("edge_cont_count", wr_n - w0, 18);
        for (int k = 0; k < 9; k++) begin
            check("edge_cont_addr", wr_addr[w0 + 9 + k], 9 + k);
            check("edge_cont_data", wr_data[w0 + 9 + k], 16'h0077 + 16'h0011 * k);
        end
        check("edge_last_word", wr_data[w0 + 17], 16'h00FF);

        // Bad CRC frame
        base = clr_n;
        begin_frame(8'h03, 8'h02); fq.push_back(8'hF0); fq.push_back(8'h48);
        send_fq();
        wait_cyc(5);
        check("badcrc_no_clear", clr_n, base);
        check("badcrc_err_cnt", err_cnt, 1);

        // STATUS: ptr=18, last_err=1, err=1; then again with last_err cleared
        check_status("status1", 8'h91, 8'h01);
        check_status("status2", 8'h90, 8'h01);

        // Inter-byte timeout, then a normal SWAP
        begin_frame(8'h03, 8'h02);
        send_fq();
        wait_cyc(70);
        check("timeout_err", err_cnt, 2);
        begin_frame(8'h02, 8'h01); fq.push_back(8'h2D);
        send_fq();
        @(negedge CLK); @(negedge CLK);
        check("timeout_swap_req", swap_req, 1);
        @(posedge CLK); #1 swap_ack = 1'b1;
        @(posedge CLK); #1 swap_ack = 1'b0;
        check("timeout_swap_drop", swap_req, 0);
        check("timeout_swap_err", err_cnt, 2);

        // LEN boundaries and unknown command
        send_byte(8'hAA); send_byte(8'h00);
        wait_cyc(3);
        check("len0_err", err_cnt, 3);
        send_byte(8'hAA); send_byte(8'h21);
        wait_cyc(3);
        check("len33_err", err_cnt, 4);
        send_byte(8'hAA); send_byte(8'h01);
        wait_cyc(3);
        check("len1_err", err_cnt, 5);
        begin_frame(8'h02, 8'h03); add_crc();
        send_fq();
        wait_cyc(4);
        check("badcmd_err", err_cnt, 6);

        // Reset in the middle of an edge load
        w0 = wr_n;
        begin_frame(8'h16, 8'h05); fq.push_back(8'h03); fq.push_back(8'h00);
        for (int k = 1; k <= 9; k++) begin fq.push_back(8'h00); fq.push_back(8'(k * 17)); end
        add_crc();
        send_fq();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK); #1 rst = 1'b1;
        wait_cyc(3);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_edge_we", edge_we, 0);
        rst = 1'b0;
        wait_cyc(20);
        check("midrst_writes", wr_n - w0, 2);
        check_status("status_rst", 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
